// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, key classes and the 4x4 keymap decode.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {KEY_DIGIT, KEY_OP, KEY_EQ, KEY_CE} key_class_e;

  typedef struct packed {
    key_class_e cls;
    logic [3:0] value;
  } key_info_t;

  // Column 3 holds the operators, ordered by row to match the op codes.
  function automatic key_info_t decode_key(input logic [1:0] row, input logic [1:0] col);
    key_info_t k;
    k.cls   = KEY_DIGIT;
    k.value = 4'd0;
    if (col == 2'd3) begin
      k.cls   = KEY_OP;
      k.value = {2'b00, row};
    end else if (row == 2'd3) begin
      unique case (col)
        2'd0:    k.cls = KEY_CE;
        2'd1:    k.value = 4'd0;
        default: k.cls = KEY_EQ;
      endcase
    end else begin
      k.value = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs; resets to all-released.
module keypad_row_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [Width-1:0] row_n,
  output logic [Width-1:0] rs
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_n;
      sync_q <= meta_q;
    end
  end

  assign rs = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, debounced press/release tracking and key event decode.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       num_pressed,
  output logic [3:0] digit,
  output logic       op_selected,
  output logic [1:0] op_code,
  output logic       eq_pressed,
  output logic       ce_pressed
);

  localparam int unsigned TimerW = $clog2(SCAN_DIV);
  localparam int unsigned CntW   = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {StScan, StDebounce, StEmit, StRelease} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        digit_q, digit_d;
  logic [1:0]        op_q, op_d;

  logic [3:0] rs;
  logic       tc;
  logic       hit;
  logic [1:0] hit_row;
  logic       reach;
  key_info_t  new_key, emit_key;

  keypad_row_sync #(
    .Width(4)
  ) u_row_sync (
    .clk  (clk),
    .clear(clear),
    .row_n(row_n),
    .rs   (rs)
  );

  assign tc       = (timer_q == TimerW'(SCAN_DIV - 1));
  assign reach    = ((cnt_q + CntW'(1)) == CntW'(DEBOUNCE_SCANS));
  assign new_key  = decode_key(hit_row, col_q);
  assign emit_key = decode_key(row_q, col_q);

  // Exactly one row low means a single unambiguous key in the driven column.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    unique case (rs)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    op_d    = op_q;
    unique case (state_q)
      StScan: begin
        if (tc) begin
          if (hit) begin
            row_d = hit_row;
            cnt_d = CntW'(1);
            state_d = (DEBOUNCE_SCANS == 1) ? StEmit : StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      StDebounce: begin
        if (tc) begin
          if (hit && hit_row == row_q) begin
            cnt_d = cnt_q + CntW'(1);
            if (reach) state_d = StEmit;
          end else begin
            state_d = StScan;
            col_d   = col_q + 2'd1;
          end
        end
      end
      StEmit: begin
        cnt_d   = '0;
        state_d = StRelease;
      end
      default: begin
        if (tc) begin
          if (rs == 4'b1111) begin
            cnt_d = cnt_q + CntW'(1);
            if (reach) begin
              state_d = StScan;
              col_d   = col_q + 2'd1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
    endcase
    // Load the value on entry to emit so it is already valid alongside the pulse.
    if (state_d == StEmit && state_q != StEmit) begin
      if (new_key.cls == KEY_DIGIT) digit_d = new_key.value;
      if (new_key.cls == KEY_OP)    op_d    = new_key.value[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StScan;
      timer_q <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      digit_q <= 4'd0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      timer_q <= tc ? '0 : timer_q + TimerW'(1);
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    num_pressed = 1'b0;
    op_selected = 1'b0;
    eq_pressed  = 1'b0;
    ce_pressed  = 1'b0;
    if (state_q == StEmit && !clear) begin
      unique case (emit_key.cls)
        KEY_DIGIT: num_pressed = 1'b1;
        KEY_OP:    op_selected = 1'b1;
        KEY_EQ:    eq_pressed  = 1'b1;
        default:   ce_pressed  = 1'b1;
      endcase
    end
  end

  assign col_n   = ~(4'b0001 << col_q);
  assign digit   = digit_q;
  assign op_code = op_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a matrix model drives rows, a monitor checks every key event.
module tb_keypad_scanner;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       num_pressed, op_selected, eq_pressed, ce_pressed;
  logic [3:0] digit;
  logic [1:0] op_code;
  logic [15:0] held = '0;

  typedef struct {
    key_class_e cls;
    logic [3:0] value;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .row_n      (row_n),
    .col_n      (col_n),
    .num_pressed(num_pressed),
    .digit      (digit),
    .op_selected(op_selected),
    .op_code    (op_code),
    .eq_pressed (eq_pressed),
    .ce_pressed (ce_pressed)
  );

  always #5 clk = ~clk;

  // A held key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0]  p;
    exp_t        e;
    key_class_e  got_cls;
    logic [3:0]  got_val;
    p = {num_pressed, op_selected, eq_pressed, ce_pressed};
    if (p != 4'b0000) begin
      check("pulse_onehot", 32'($countones(p)), 32'd1);
      check("pulse_during_clear", 32'(clear), 32'd0);
      got_cls = num_pressed ? KEY_DIGIT : op_selected ? KEY_OP : eq_pressed ? KEY_EQ : KEY_CE;
      got_val = num_pressed ? digit : op_selected ? {2'b00, op_code} : 4'd0;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: pulses=%b required none", p);
      end else begin
        e = sb_q.pop_front();
        check("event_class", 32'(got_cls), 32'(e.cls));
        check("event_value", 32'(got_val), 32'(e.value));
      end
    end
  end

  task automatic expect_key(input key_class_e cls, input logic [3:0] v);
    exp_t e;
    e.cls   = cls;
    e.value = v;
    sb_q.push_back(e);
  endtask

  task automatic press(input int r, input int c, input key_class_e cls, input logic [3:0] v);
    held[r*4+c] = 1'b1;
    expect_key(cls, v);
    repeat (60) @(posedge clk);
    held = '0;
    repeat (60) @(posedge clk);
  endtask

  task automatic wait_col(input logic [3:0] want, input logic equal);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(posedge clk);
      #1;
      ok = equal ? (col_n == want) : (col_n != want);
    end
    check("col_wait_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [3:0] rot [4];
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

    // Reset and column rotation
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_col_n", 32'(col_n), 32'h e);
    check("rst_pulses", 32'({num_pressed, op_selected, eq_pressed, ce_pressed}), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_op_code", 32'(op_code), 32'd0);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("col_rotate", 32'(col_n), 32'(rot[i]));
    end

    // Long hold of '5'
    press(1, 1, KEY_DIGIT, 4'd5);

    // Bouncing '7': expectation only armed once contact is stable
    for (int i = 0; i < 8; i++) begin
      held[8] = (i % 2 == 0);
      repeat (3) @(posedge clk);
    end
    press(2, 0, KEY_DIGIT, 4'd7);

    press(1, 3, KEY_OP, {2'b00, OP_SUB});
    press(3, 3, KEY_OP, {2'b00, OP_DIV});
    press(3, 2, KEY_EQ, 4'd0);
    press(3, 0, KEY_CE, 4'd0);

    // '1' and '4' share a column: rejected until '4' lets go
    held[0] = 1'b1;
    held[4] = 1'b1;
    repeat (40) @(posedge clk);
    held[4] = 1'b0;
    press(0, 0, KEY_DIGIT, 4'd1);

    // clear in the middle of debouncing '9'
    held[10] = 1'b1;
    wait_col(4'b1011, 1'b0);
    wait_col(4'b1011, 1'b1);
    repeat (5) @(posedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear_col_n", 32'(col_n), 32'h e);
    clear = 1'b0;
    press(2, 2, KEY_DIGIT, 4'd9);

    check("events_outstanding", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
